// File: rtl/cr_kme_fifo_unpack.sv
// Serialises each IN_WIDTH-bit KME RAM FIFO word into IN_WIDTH/OUT_WIDTH beats, LSB slice first.
// Optional even parity on out_data is enabled by defining CR_KME_UNPACK_PARITY_EN.
module cr_kme_fifo_unpack #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ack,
    input  logic                 in_mbe,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_err,
    output logic                 out_par,
    output logic                 err_sticky,
    input  logic                 err_clr
);

    localparam int N_BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W  = $clog2(N_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_p0;
    state_t               state_nxt;
    logic [IN_WIDTH-1:0]  hold_p0;
    logic [BEAT_W-1:0]    beat_p0;
    logic                 werr_p0;
    logic                 sticky_p0;
    logic                 load;
    logic                 adv;
    logic                 is_shift;
    logic                 is_last;

    assign is_shift = (state_p0 == SHIFT);
    assign is_last  = (beat_p0 == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // A pop on the last beat's acceptance lets the next word follow without a bubble
    always_comb begin
        state_nxt = state_p0;
        in_ack    = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state_p0)
            IDLE: begin
                in_ack = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ack) begin
                    if (is_last) begin
                        in_ack = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold stage: captured word, beat pointer, word error flag, sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_p0   <= '0;
            beat_p0   <= '0;
            werr_p0   <= 1'b0;
            sticky_p0 <= 1'b0;
        end else begin
            if (load) begin
                hold_p0 <= in_data;
                werr_p0 <= in_mbe;
                beat_p0 <= '0;
            end else if (adv) begin
                beat_p0 <= beat_p0 + BEAT_W'(1);
            end
            if (load && in_mbe) begin
                sticky_p0 <= 1'b1;
            end else if (err_clr) begin
                sticky_p0 <= 1'b0;
            end
        end
    end

    assign out_valid  = is_shift;
    assign out_data   = is_shift ? hold_p0[int'(beat_p0)*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign out_first  = is_shift && (beat_p0 == '0);
    assign out_last   = is_shift && is_last;
    assign out_err    = is_shift && werr_p0;
    assign err_sticky = sticky_p0;

`ifdef CR_KME_UNPACK_PARITY_EN
    function automatic logic even_par(input logic [OUT_WIDTH-1:0] d);
        return ^d;
    endfunction

    logic par_p0;

    // Parity of the beat about to be presented, registered with the beat pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_p0 <= 1'b0;
        end else if (load) begin
            par_p0 <= even_par(in_data[OUT_WIDTH-1:0]);
        end else if (adv) begin
            par_p0 <= even_par(hold_p0[(int'(beat_p0) + 1)*OUT_WIDTH +: OUT_WIDTH]);
        end
    end

    assign out_par = is_shift && par_p0;
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_unpack.sv
// Directed bench for cr_kme_fifo_unpack: per-cycle vector table plus reset and parity sequences.
module tb_cr_kme_fifo_unpack;

    logic         clk;
    logic         rst;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ack;
    logic         in_mbe;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ack;
    logic         out_first;
    logic         out_last;
    logic         out_err;
    logic         out_par;
    logic         err_sticky;
    logic         err_clr;

    int n_cmp;
    int n_err;

    cr_kme_fifo_unpack #(.IN_WIDTH(256), .OUT_WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .in_mbe    (in_mbe),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_first (out_first),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_par   (out_par),
        .err_sticky(err_sticky),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] W0 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                   64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    localparam logic [255:0] W1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] W2 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [255:0] WP = {64'h0, 64'h0, 64'h3, 64'h1};

    typedef struct {
        logic         iv;
        logic [255:0] d;
        logic         mbe;
        logic         oa;
        logic         clr;
        logic         ev;
        logic [63:0]  ed;
        logic         ef;
        logic         el;
        logic         ee;
        logic         eia;
        logic         es;
    } vec_t;

    vec_t tv[$];

    function automatic logic exp_par(input logic [63:0] d, input logic ev);
`ifdef CR_KME_UNPACK_PARITY_EN
        return ev & (^d);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [255:0] d, input logic mbe, input logic oa,
                       input logic clr, input logic ev, input logic [63:0] ed, input logic ef,
                       input logic el, input logic ee, input logic eia, input logic es);
        vec_t v;
        v.iv = iv; v.d = d; v.mbe = mbe; v.oa = oa; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ef = ef; v.el = el; v.ee = ee; v.eia = eia; v.es = es;
        tv.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [63:0] ed, input logic ef,
                           input logic el, input logic ee, input logic eia, input logic es);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".out_data"}, out_data, ed);
        chk({tag, ".out_first"}, 64'(out_first), 64'(ef));
        chk({tag, ".out_last"}, 64'(out_last), 64'(el));
        chk({tag, ".out_err"}, 64'(out_err), 64'(ee));
        chk({tag, ".in_ack"}, 64'(in_ack), 64'(eia));
        chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(es));
        chk({tag, ".out_par"}, 64'(out_par), 64'(exp_par(ed, ev)));
    endtask

    task automatic drive(input logic iv, input logic [255:0] d, input logic mbe, input logic oa,
                         input logic clr);
        @(negedge clk);
        in_valid = iv; in_data = d; in_mbe = mbe; out_ack = oa; err_clr = clr;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mbe = 1'b0; out_ack = 1'b0; err_clr = 1'b0;
        #1;
        chk_all("reset", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // iv  d   mbe oa clr | ev  ed                     ef el ee ia st
        add(1, W0, 0, 1, 0,   0, 64'h0,                    0, 0, 0, 1, 0);
        add(1, W1, 1, 1, 0,   1, 64'h0,                    1, 0, 0, 0, 0);
        add(1, W1, 1, 1, 0,   1, 64'h1111_1111_1111_1111,  0, 0, 0, 0, 0);
        add(1, W1, 1, 1, 0,   1, 64'h2222_2222_2222_2222,  0, 0, 0, 0, 0);
        add(1, W1, 1, 1, 0,   1, 64'h3333_3333_3333_3333,  0, 1, 0, 1, 0);
        add(1, W2, 0, 1, 0,   1, 64'hAAAA_AAAA_AAAA_AAAA,  1, 0, 1, 0, 1);
        add(1, W2, 0, 1, 0,   1, 64'hBBBB_BBBB_BBBB_BBBB,  0, 0, 1, 0, 1);
        add(1, W2, 0, 1, 0,   1, 64'hCCCC_CCCC_CCCC_CCCC,  0, 0, 1, 0, 1);
        add(1, W2, 0, 1, 0,   1, 64'hDDDD_DDDD_DDDD_DDDD,  0, 1, 1, 1, 1);
        add(0, W2, 0, 1, 0,   1, 64'h5555_5555_5555_5555,  1, 0, 0, 0, 1);
        add(0, W2, 0, 1, 0,   1, 64'h6666_6666_6666_6666,  0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, W2, 0, 0, 0, 1, 64'h7777_7777_7777_7777, 0, 0, 0, 0, 1);
        add(0, W2, 0, 1, 0,   1, 64'h7777_7777_7777_7777,  0, 0, 0, 0, 1);
        add(1, W0, 1, 0, 0,   1, 64'h8888_8888_8888_8888,  0, 1, 0, 0, 1);
        add(0, W0, 0, 1, 0,   1, 64'h8888_8888_8888_8888,  0, 1, 0, 1, 1);
        add(0, W0, 0, 1, 1,   0, 64'h0,                    0, 0, 0, 1, 1);
        add(1, W0, 1, 1, 1,   0, 64'h0,                    0, 0, 0, 1, 0);
        add(0, W0, 0, 1, 0,   1, 64'h0,                    1, 0, 1, 0, 1);
        add(0, W0, 0, 1, 0,   1, 64'h1111_1111_1111_1111,  0, 0, 1, 0, 1);
        add(0, W0, 0, 1, 0,   1, 64'h2222_2222_2222_2222,  0, 0, 1, 0, 1);
        add(0, W0, 0, 1, 0,   1, 64'h3333_3333_3333_3333,  0, 1, 1, 1, 1);
        add(0, W0, 0, 1, 0,   0, 64'h0,                    0, 0, 0, 1, 1);

        foreach (tv[i]) begin
            drive(tv[i].iv, tv[i].d, tv[i].mbe, tv[i].oa, tv[i].clr);
            chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].ef, tv[i].el,
                    tv[i].ee, tv[i].eia, tv[i].es);
        end

        // Async reset in the middle of a word with the sticky flag set
        drive(1, W2, 1, 1, 0);
        drive(0, W2, 0, 1, 0);
        chk_all("rst_pre", 1'b1, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(0, W2, 0, 0, 0);
        chk_all("rst_mid", 1'b1, 64'h6666_6666_6666_6666, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, W0, 0, 1, 0);
        chk_all("rst_idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(0, W0, 0, 1, 0);
        chk_all("rst_beat0", 1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, W0, 0, 1, 0);
        chk_all("rst_beat1", 1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(0, W0, 0, 1, 0);
        chk_all("rst_drained", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Parity word: beat 0 = 1 (odd), beat 1 = 3 (even)
        drive(1, WP, 0, 1, 0);
        drive(0, WP, 0, 1, 0);
        chk_all("par_b0", 1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, WP, 0, 1, 0);
        chk_all("par_b1", 1'b1, 64'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, WP, 0, 1, 0);
        chk_all("par_b2", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, WP, 0, 1, 0);
        chk_all("par_b3", 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
